// File: rtl/comparador_serial_der_izq_if.sv
// Handshake and result bundle for the LSB-first serial magnitude comparator.
// The master drives the operand bits; the slave (comparator) answers with status and result.
interface comparador_serial_der_izq_if;
    logic start;
    logic in_valid;
    logic in_ready;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic a_gt_b;
    logic a_lt_b;
    logic a_eq_b;

    modport master (
        output start, in_valid, a_bit, b_bit,
        input  in_ready, busy, done, a_gt_b, a_lt_b, a_eq_b
    );

    modport slave (
        input  start, in_valid, a_bit, b_bit,
        output in_ready, busy, done, a_gt_b, a_lt_b, a_eq_b
    );
endinterface

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial magnitude comparator, operands arrive LSB first; each more significant
// differing bit overrides the running relation, so the final relation is the MSB-most difference.
module comparador_serial_der_izq #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    comparador_serial_der_izq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Relation (M,N): 11 = EQ, 10 = GT, 01 = LT; 00 never occurs.
    localparam logic [1:0] REL_EQ = 2'b11;
    localparam logic [1:0] REL_GT = 2'b10;
    localparam logic [1:0] REL_LT = 2'b01;

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    rel, rel_upd;
    logic          xfer, last, clear;

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = SHIFT;
            SHIFT: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (bus.in_valid && cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = bus.start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign xfer  = bus.in_valid && (state == SHIFT);
    assign last  = xfer && (cnt == LAST);
    assign clear = bus.start && (state == IDLE || state == DONE);

    always_comb begin
        rel_upd = rel;
        if (bus.a_bit != bus.b_bit) rel_upd = bus.a_bit ? REL_GT : REL_LT;
    end

    // Results load on the final transfer so they are already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rel        <= REL_EQ;
            bus.a_gt_b <= 1'b0;
            bus.a_lt_b <= 1'b0;
            bus.a_eq_b <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                cnt        <= '0;
                rel        <= REL_EQ;
                bus.a_gt_b <= 1'b0;
                bus.a_lt_b <= 1'b0;
                bus.a_eq_b <= 1'b0;
            end else if (xfer) begin
                rel <= rel_upd;
                if (last) begin
                    bus.a_gt_b <= (rel_upd == REL_GT);
                    bus.a_lt_b <= (rel_upd == REL_LT);
                    bus.a_eq_b <= (rel_upd == REL_EQ);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule
